// File: rtl/spi_burst_ctrl_if.sv
// spi_burst_ctrl_if: command, payload, read-data and transceiver FIFO signals of spi_burst_ctrl
interface spi_burst_ctrl_if #(
    parameter int LEN_W = 4
);
    logic             cmdValid;
    logic             cmdReady;
    logic             cmdRead;
    logic [6:0]       cmdAddr;
    logic [LEN_W-1:0] cmdLen;
    logic [7:0]       wrData;
    logic             wrValid;
    logic             wrReady;
    logic [7:0]       rdData;
    logic             rdValid;
    logic             rdReady;
    logic             busy;
    logic             done;
    logic [7:0]       xcvrDataIn;
    logic             xcvrWrite;
    logic             xcvrTxFull;
    logic             xcvrRead;
    logic             xcvrRxDataPresent;
    logic [7:0]       xcvrDataOut;

    modport slave (
        input  cmdValid, cmdRead, cmdAddr, cmdLen, wrData, wrValid, rdReady,
               xcvrTxFull, xcvrRxDataPresent, xcvrDataOut,
        output cmdReady, wrReady, rdData, rdValid, busy, done, xcvrDataIn, xcvrWrite, xcvrRead
    );

    modport master (
        output cmdValid, cmdRead, cmdAddr, cmdLen, wrData, wrValid, rdReady,
               xcvrTxFull, xcvrRxDataPresent, xcvrDataOut,
        input  cmdReady, wrReady, rdData, rdValid, busy, done, xcvrDataIn, xcvrWrite, xcvrRead
    );
endinterface

// File: rtl/spi_burst_ctrl.sv
// spi_burst_ctrl: turns a register-burst command into header + data bytes for the SPI transceiver FIFOs and returns read bytes
module spi_burst_ctrl #(
    parameter int         LEN_W = 4,
    parameter logic [7:0] DUMMY = 8'h00
) (
    input logic             clk,
    input logic             rst,
    spi_burst_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, HEADER, DATA, DRAIN, DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_read;
    logic [6:0]       r_addr;
    logic [LEN_W-1:0] r_tx_left;
    logic [LEN_W:0]   r_rx_left;
    logic [LEN_W:0]   r_rx_idx;
    logic             r_cmd_ready;
    logic             r_busy;
    logic             r_done;
    logic             r_xcvr_write;
    logic             r_xcvr_read;
    logic [7:0]       r_xcvr_data_in;
    logic             r_rd_valid;
    logic [7:0]       r_rd_data;

    logic w_accept;
    logic w_tx_ok;
    logic w_hdr_push;
    logic w_data_tx;
    logic w_wr_push;
    logic w_dummy_push;
    logic w_rx_active;
    logic w_fwd;
    logic w_pop;

    // the strobe registers double as gap flags: no new push/pop is decided while a strobe is out
    assign w_tx_ok      = !bus.xcvrTxFull && !r_xcvr_write;
    assign w_accept     = (r_state == IDLE) && r_cmd_ready && bus.cmdValid;
    assign w_hdr_push   = (r_state == HEADER) && w_tx_ok;
    assign w_data_tx    = (r_state == DATA) && (r_tx_left != '0) && w_tx_ok;
    assign w_wr_push    = w_data_tx && !r_read && bus.wrValid;
    assign w_dummy_push = w_data_tx && r_read;
    assign w_rx_active  = (r_state == HEADER) || (r_state == DATA) || (r_state == DRAIN);
    assign w_fwd        = r_read && (r_rx_idx != '0);
    assign w_pop        = w_rx_active && bus.xcvrRxDataPresent && (r_rx_left != '0) && !r_xcvr_read &&
                          (!w_fwd || !r_rd_valid || bus.rdReady);

    assign bus.wrReady    = w_data_tx && !r_read;
    assign bus.cmdReady   = r_cmd_ready;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.xcvrWrite  = r_xcvr_write;
    assign bus.xcvrRead   = r_xcvr_read;
    assign bus.xcvrDataIn = r_xcvr_data_in;
    assign bus.rdValid    = r_rd_valid;
    assign bus.rdData     = r_rd_data;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // next-state: TX side advances HEADER->DATA->DRAIN, RX side gates DRAIN->DONE
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    w_next = w_accept ? HEADER : IDLE;
            HEADER:  w_next = w_hdr_push ? DATA : HEADER;
            DATA:    w_next = (r_tx_left == '0) ? DRAIN : DATA;
            DRAIN:   w_next = (r_rx_left == '0 && !r_rd_valid) ? DONE : DRAIN;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // command latch, byte counters, and registered FIFO strobes / status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_read         <= 1'b0;
            r_addr         <= '0;
            r_tx_left      <= '0;
            r_rx_left      <= '0;
            r_rx_idx       <= '0;
            r_cmd_ready    <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_xcvr_write   <= 1'b0;
            r_xcvr_read    <= 1'b0;
            r_xcvr_data_in <= '0;
            r_rd_valid     <= 1'b0;
            r_rd_data      <= '0;
        end else begin
            if (w_accept) begin
                r_read    <= bus.cmdRead;
                r_addr    <= bus.cmdAddr;
                r_tx_left <= bus.cmdLen;
                r_rx_left <= {1'b0, bus.cmdLen} + (LEN_W+1)'(1);
                r_rx_idx  <= '0;
            end else begin
                if (w_wr_push || w_dummy_push) r_tx_left <= r_tx_left - LEN_W'(1);
                if (w_pop) begin
                    r_rx_left <= r_rx_left - (LEN_W+1)'(1);
                    r_rx_idx  <= r_rx_idx + (LEN_W+1)'(1);
                end
            end
            r_cmd_ready    <= (w_next == IDLE);
            r_busy         <= (w_next != IDLE);
            r_done         <= (w_next == DONE);
            r_xcvr_write   <= w_hdr_push || w_wr_push || w_dummy_push;
            r_xcvr_read    <= w_pop;
            r_xcvr_data_in <= w_hdr_push ? {r_read, r_addr} : w_wr_push ? bus.wrData :
                              w_dummy_push ? DUMMY : r_xcvr_data_in;
            r_rd_valid     <= (w_pop && w_fwd) || (r_rd_valid && !bus.rdReady);
            if (w_pop && w_fwd) r_rd_data <= bus.xcvrDataOut;
        end
    end
endmodule

// File: tb/tb_spi_burst_ctrl.sv
// tb_spi_burst_ctrl: table-driven and randomized checks of spi_burst_ctrl against a transceiver/consumer model
module tb_spi_burst_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_burst_ctrl_if #(.LEN_W(4)) bus ();
    spi_burst_ctrl #(.LEN_W(4), .DUMMY(8'h00)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        bit          rd;
        logic [6:0]  addr;
        int          len;
        logic [39:0] b;
        logic [39:0] exp_tx;
        int          n_tx;
        logic [31:0] exp_rd;
        int          n_rd;
        int          rd_stall;
        int          tx_stall;
        int          hold;
    } vec_t;

    int tests = 0, fails = 0, cyc = 0;
    logic [7:0] wr_q[$], rx_src[$], rx_fifo[$], tx_log[$], rd_log[$], exp_tx[$], exp_rd[$];
    logic [7:0] pend_b[$];
    int pend_t[$];
    int pops, dones, accepts, consec, wr_full, hold_viol, rd_at_done, pops_blk;
    int rd_block = 0, tx_stall_req = 0, tx_stall = 0;
    bit stall_armed, rand_ready = 0, rand_full = 0, prev_wr = 0, prev_full = 0, prev_hold = 0;
    logic [7:0] prev_rd = 8'h00;
    logic full_now;

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    function automatic int outs();
        return int'({bus.cmdReady, bus.wrReady, bus.rdValid, bus.busy, bus.done,
                     bus.xcvrWrite, bus.xcvrRead, bus.rdData, bus.xcvrDataIn});
    endfunction

    // transceiver FIFO model, payload source and read consumer: drive on negedge, observe 2 time units later
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            rx_fifo.delete();
            pend_b.delete();
            pend_t.delete();
        end
        while (pend_t.size() > 0 && pend_t[0] <= cyc) begin
            rx_fifo.push_back(pend_b.pop_front());
            void'(pend_t.pop_front());
        end
        if (tx_stall_req > 0 && !stall_armed && tx_log.size() >= 2) begin
            tx_stall = tx_stall_req;
            stall_armed = 1'b1;
        end
        full_now = (tx_stall > 0) || (rand_full && $urandom_range(3) == 0);
        if (tx_stall > 0) tx_stall--;
        if (rd_block == 1) pops_blk = pops;
        bus.rdReady = (rd_block > 0) ? 1'b0 : rand_ready ? 1'($urandom_range(1)) : 1'b1;
        if (rd_block > 0) rd_block--;
        bus.xcvrTxFull = full_now;
        bus.xcvrRxDataPresent = rx_fifo.size() > 0;
        bus.xcvrDataOut = (rx_fifo.size() > 0) ? rx_fifo[0] : 8'h00;
        bus.wrValid = wr_q.size() > 0;
        bus.wrData = (wr_q.size() > 0) ? wr_q[0] : 8'h00;
        #2;
        if (bus.xcvrWrite) begin
            tx_log.push_back(bus.xcvrDataIn);
            if (prev_wr) consec++;
            if (prev_full) wr_full++;
            if (rx_src.size() > 0) begin
                pend_b.push_back(rx_src.pop_front());
                pend_t.push_back(cyc + 3);
            end
        end
        if (bus.wrReady && full_now) wr_full++;
        if (bus.xcvrRead) begin
            pops++;
            if (rx_fifo.size() > 0) void'(rx_fifo.pop_front());
        end
        if (prev_hold && (!bus.rdValid || bus.rdData != prev_rd)) hold_viol++;
        prev_hold = bus.rdValid && !bus.rdReady;
        prev_rd = bus.rdData;
        if (bus.rdValid && bus.rdReady) rd_log.push_back(bus.rdData);
        if (bus.done) begin
            dones++;
            rd_at_done = rd_log.size();
        end
        if (bus.cmdValid && bus.cmdReady) accepts++;
        if (bus.wrValid && bus.wrReady) void'(wr_q.pop_front());
        prev_wr = bus.xcvrWrite;
        prev_full = full_now;
    end

    task automatic do_reset(input string tag);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1 chk({tag, "_outs"}, outs(), 0);
        rst = 1'b0;
        #1 chk({tag, "_ready_low"}, int'(bus.cmdReady), 0);
        @(posedge clk);
        #1 chk({tag, "_ready_high"}, int'(bus.cmdReady), 1);
    endtask

    task automatic start_burst(input bit rd, input logic [6:0] addr, input int len, input int hold);
        int n = 0;
        tx_log.delete();
        rd_log.delete();
        pops = 0; dones = 0; accepts = 0; consec = 0; wr_full = 0; hold_viol = 0;
        rd_at_done = -1; pops_blk = -1; stall_armed = 1'b0;
        do @(negedge clk); while (!bus.cmdReady && ++n < 50);
        bus.cmdValid = 1'b1;
        bus.cmdRead = rd;
        bus.cmdAddr = addr;
        bus.cmdLen = 4'(len);
        repeat (hold + 1) @(negedge clk);
        bus.cmdValid = 1'b0;
    endtask

    task automatic finish_burst(input string tag, input int len);
        int n = 0;
        while ((dones == 0 || bus.busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        #3;
        chk({tag, "_tx_n"}, tx_log.size(), exp_tx.size());
        if (tx_log.size() == exp_tx.size())
            foreach (exp_tx[i]) chk($sformatf("%s_tx%0d", tag, i), int'(tx_log[i]), int'(exp_tx[i]));
        chk({tag, "_rd_n"}, rd_log.size(), exp_rd.size());
        if (rd_log.size() == exp_rd.size())
            foreach (exp_rd[i]) chk($sformatf("%s_rd%0d", tag, i), int'(rd_log[i]), int'(exp_rd[i]));
        chk({tag, "_pops"}, pops, len + 1);
        chk({tag, "_dones"}, dones, 1);
        chk({tag, "_accepts"}, accepts, 1);
        chk({tag, "_consec_wr"}, consec, 0);
        chk({tag, "_wr_when_full"}, wr_full, 0);
        chk({tag, "_rd_hold"}, hold_viol, 0);
        chk({tag, "_rd_before_done"}, rd_at_done, exp_rd.size());
        chk({tag, "_rx_left"}, rx_fifo.size(), 0);
        chk({tag, "_busy_end"}, int'(bus.busy), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t vecs[5];
        vecs[0] = '{0, 7'h12, 3, 40'h00_00_FF_5A_A5, 40'h00_FF_5A_A5_12, 4, 32'h0, 0, 0, 0, 0};
        vecs[1] = '{1, 7'h05, 2, 40'h00_00_C3_3C_EE, 40'h00_00_00_00_85, 3, 32'h0000_C3_3C, 2, 0, 0, 0};
        vecs[2] = '{1, 7'h33, 4, 40'hD4_C3_B2_A1_11, 40'h00_00_00_00_B3, 5, 32'hD4_C3_B2_A1, 4, 20, 0, 0};
        vecs[3] = '{0, 7'h40, 4, 40'h00_04_03_02_01, 40'h04_03_02_01_40, 5, 32'h0, 0, 0, 10, 0};
        vecs[4] = '{0, 7'h7F, 0, 40'h0, 40'h00_00_00_00_7F, 1, 32'h0, 0, 0, 0, 3};
        bus.cmdValid = 1'b0;
        bus.cmdRead = 1'b0;
        bus.cmdAddr = '0;
        bus.cmdLen = '0;
        do_reset("rst0");

        pops = 0;
        rx_fifo.push_back(8'h99);
        repeat (10) @(negedge clk);
        #3 chk("idle_no_pop", pops, 0);
        chk("idle_rx_kept", rx_fifo.size(), 1);
        do_reset("rst1");

        foreach (vecs[k]) begin
            wr_q.delete(); rx_src.delete(); exp_tx.delete(); exp_rd.delete();
            for (int i = 0; i <= vecs[k].len; i++) begin
                if (vecs[k].rd) rx_src.push_back(vecs[k].b[8*i +: 8]);
                else begin
                    rx_src.push_back(8'($urandom));
                    if (i < vecs[k].len) wr_q.push_back(vecs[k].b[8*i +: 8]);
                end
            end
            for (int i = 0; i < vecs[k].n_tx; i++) exp_tx.push_back(vecs[k].exp_tx[8*i +: 8]);
            for (int i = 0; i < vecs[k].n_rd; i++) exp_rd.push_back(vecs[k].exp_rd[8*i +: 8]);
            rd_block = vecs[k].rd_stall;
            tx_stall_req = vecs[k].tx_stall;
            start_burst(vecs[k].rd, vecs[k].addr, vecs[k].len, vecs[k].hold);
            finish_burst($sformatf("vec%0d", k), vecs[k].len);
            if (vecs[k].rd_stall > 0) chk($sformatf("vec%0d_pops_blocked", k), pops_blk, 2);
            tx_stall_req = 0;
        end

        rand_ready = 1'b1;
        rand_full = 1'b1;
        for (int k = 0; k < 24; k++) begin
            bit rd;
            logic [6:0] addr;
            int len;
            logic [7:0] resp;
            rd = 1'($urandom_range(1));
            addr = 7'($urandom);
            len = $urandom_range(15);
            wr_q.delete(); rx_src.delete(); exp_tx.delete(); exp_rd.delete();
            exp_tx.push_back({rd, addr});
            for (int i = 0; i <= len; i++) begin
                resp = 8'($urandom);
                rx_src.push_back(resp);
                if (rd && i > 0) exp_rd.push_back(resp);
            end
            for (int i = 0; i < len; i++) begin
                if (rd) exp_tx.push_back(8'h00);
                else begin
                    wr_q.push_back(8'($urandom));
                    exp_tx.push_back(wr_q[i]);
                end
            end
            start_burst(rd, addr, len, 0);
            finish_burst($sformatf("rnd%0d", k), len);
        end
        rand_ready = 1'b0;
        rand_full = 1'b0;

        begin
            int n = 0;
            wr_q.delete(); rx_src.delete();
            for (int i = 0; i < 9; i++) begin
                rx_src.push_back(8'($urandom));
                if (i < 8) wr_q.push_back(8'(8'h30 + i));
            end
            start_burst(1'b0, 7'h2A, 8, 0);
            while (tx_log.size() < 3 && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("mid_tx_reached", tx_log.size(), 3);
            #3 rst = 1'b1;
            #1 chk("rst_async_outs", outs(), 0);
            wr_q.delete(); rx_src.delete();
            do_reset("rst2");
        end

        wr_q.delete(); rx_src.delete(); exp_tx.delete(); exp_rd.delete();
        rx_src.push_back(8'h5A);
        rx_src.push_back(8'h77);
        exp_tx.push_back(8'hE1);
        exp_tx.push_back(8'h00);
        exp_rd.push_back(8'h77);
        start_burst(1'b1, 7'h61, 1, 0);
        finish_burst("post_rst", 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/spi_burst_ctrl.md
Name: spi_burst_ctrl

Overview:
- Command sequencer that sits directly upstream of the SPI master transceiver and drives its FIFO-side interface (dataIn/write/read, txFull/rxDataPresent/dataOut).
- Converts one register-burst command (read/write flag, 7-bit address, byte count) into a header byte plus N data bytes pushed into the TX FIFO.
- Drains the matching N+1 bytes from the RX FIFO. Returns read data over a valid/ready stream; echo bytes from writes are discarded.

Parameters:
- LEN_W, 4, width of cmdLen. Burst carries 0..2^LEN_W-1 data bytes.
- DUMMY, 8'h00, byte transmitted during read bursts.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- cmdValid  in  1  command offered
- cmdReady  out  1  command accepted when cmdValid&cmdReady
- cmdRead  in  1  1=read burst, 0=write burst
- cmdAddr  in  7  register address
- cmdLen  in  LEN_W  data byte count
- wrData  in  8  write payload byte
- wrValid  in  1  payload byte offered
- wrReady  out  1  payload byte accepted when wrValid&wrReady
- rdData  out  8  read byte
- rdValid  out  1  read byte valid
- rdReady  in  1  consumer accepts read byte
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse at burst completion
- xcvrDataIn  out  8  byte to transceiver TX FIFO
- xcvrWrite  out  1  TX FIFO write strobe
- xcvrTxFull  in  1  TX FIFO full
- xcvrRead  out  1  RX FIFO read strobe
- xcvrRxDataPresent  in  1  RX FIFO non-empty
- xcvrDataOut  in  8  RX FIFO head (first-word fall-through, valid while xcvrRxDataPresent)

Behaviour:
- Reset, asynchronous: state=IDLE, all counters 0, cmdReady=0, and wrReady=0. xcvrWrite, xcvrRead, rdValid, busy and done are 0. rdData=0, xcvrDataIn=0. cmdReady rises the first cycle after rst deasserts.
- All outputs are registered except wrReady, which is combinational from state/counters/xcvrTxFull/gap flag.
- States: IDLE, HEADER, DATA, DRAIN, DONE.
- IDLE: cmdReady=1, busy=0. On accept, latch cmdRead, cmdAddr and cmdLen. Set txLeft=cmdLen, rxLeft=cmdLen+1 (LEN_W+1 bits) and rxIdx=0, then go to HEADER. cmdReady=0 and busy=1 until DONE exits.
- HEADER: when !xcvrTxFull and !txGap, pulse xcvrWrite for 1 cycle with xcvrDataIn={cmdRead,cmdAddr}, then go to DATA.
- txGap: after every xcvrWrite pulse, no write is issued on the next cycle, so a registered txFull is always seen. Maximum push rate is 1 byte per 2 cycles.
- DATA: if txLeft==0, go to DRAIN.
  - Write burst: wrReady = !xcvrTxFull & !txGap. On handshake, write wrData and decrement txLeft.
  - Read burst: wrReady=0. Write DUMMY when !xcvrTxFull & !txGap, and decrement txLeft.
- RX drain runs in HEADER, DATA and DRAIN in parallel with TX.
  - Pop condition: xcvrRxDataPresent & rxLeft!=0 & !rxGap, and, if the byte is forwarded, !rdValid or rdReady that cycle.
  - On pop: pulse xcvrRead, decrement rxLeft, increment rxIdx. One-cycle rxGap follows each pop.
  - Forwarded: byte with rxIdx>=1 in a read burst; capture into rdData and set rdValid. Discarded: rxIdx==0 header echo, and every byte of a write burst.
  - rdValid holds until rdValid&rdReady. rdData is stable while rdValid&!rdReady.
- DRAIN: when rxLeft==0 and !rdValid, go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- cmdLen=0: header only. 1 byte pushed, 1 byte drained, done pulses, no rdValid.
- Unexpected RX bytes in IDLE are left in the FIFO and never popped.
- Reset mid-burst aborts immediately with no further strobes. Transceiver FIFOs must share rst.

Test Plan:
- Write burst addr=0x12, len=3, payload A5,5A,FF, txFull=0 → TX sequence 12,A5,5A,FF. 4 RX bytes popped, rdValid never set, done pulse once, busy low after.
- Read burst addr=0x05, len=2, RX returns XX,3C,C3 → TX 85,00,00. rdData 3C then C3. done only after C3 consumed.
- Read len=4 with rdReady low for 20 cycles → at most 1 byte held in rdData. rdValid and rdData stable. No xcvrRead while blocked. All 4 bytes delivered in order after release.
- xcvrTxFull held high for 10 cycles mid write burst → no xcvrWrite, wrReady=0. Resume with no lost or duplicated byte. Writes are never on consecutive cycles.
- cmdLen=0, addr=0x7F, write → single byte 7F sent, one pop, done pulse. cmdValid during busy is not accepted.
- rst asserted after 2nd data byte of len=8 → all outputs 0 in the same cycle (asynchronous). After release, a new len=1 burst completes correctly.
